// File: rtl/store_commit_buffer.sv
// Store commit buffer: speculative queue (LSU stores awaiting commit) feeding a
// commit queue that drains to the D$ in order through a REQ/WAIT handshake FSM.
// Optional feature macro: STB_PAGE_OFFSET_CHECK_EN (precise load page-offset
// hazard check; default build stalls loads whenever any store is pending).
module store_commit_buffer #(
  parameter int unsigned DEPTH_SPEC   = 4,
  parameter int unsigned DEPTH_COMMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] paddr_i,
  input  logic [63:0] data_i,
  input  logic [7:0]  be_i,
  input  logic [1:0]  data_size_i,
  input  logic        commit_i,
  output logic        commit_ready_o,
  output logic        no_st_pending_o,
  output logic        store_buffer_empty_o,
  input  logic [11:0] page_offset_i,
  output logic        page_offset_matches_o,
  output logic        req_o,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o,
  output logic [7:0]  be_o,
  output logic [1:0]  size_o,
  input  logic        gnt_i,
  input  logic        rvalid_i
);

  localparam int unsigned SPW = $clog2(DEPTH_SPEC);
  localparam int unsigned CMW = $clog2(DEPTH_COMMIT);
  localparam logic [SPW:0] SPEC_FULL   = DEPTH_SPEC[SPW:0];
  localparam logic [CMW:0] COMMIT_FULL = DEPTH_COMMIT[CMW:0];

  typedef struct packed {
    logic [63:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  entry_t         spec_mem   [DEPTH_SPEC];
  entry_t         commit_mem [DEPTH_COMMIT];
  logic [SPW-1:0] spec_rd, spec_wr;
  logic [SPW:0]   spec_cnt;
  logic [CMW-1:0] commit_rd, commit_wr;
  logic [CMW:0]   commit_cnt;
  state_e         state;

  logic push, commit, pop;

  assign ready_o        = (spec_cnt != SPEC_FULL);
  assign commit_ready_o = (commit_cnt != COMMIT_FULL);
  assign push   = valid_i && ready_o && !flush_i;
  assign commit = commit_i && (spec_cnt != '0) && commit_ready_o;
  assign pop    = (state == WAIT) && rvalid_i;

  // Speculative queue pointers/count; flush discards everything left after a same-cycle commit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_rd  <= '0;
      spec_wr  <= '0;
      spec_cnt <= '0;
    end else if (flush_i) begin
      spec_rd  <= '0;
      spec_wr  <= '0;
      spec_cnt <= '0;
    end else begin
      if (push)   spec_wr <= spec_wr + 1'b1;
      if (commit) spec_rd <= spec_rd + 1'b1;
      spec_cnt <= spec_cnt + (SPW+1)'(push) - (SPW+1)'(commit);
    end
  end

  // Queue storage: LSU push into spec tail, commit copies spec head into commit tail
  always_ff @(posedge clk_i) begin
    if (push)   spec_mem[spec_wr]     <= '{paddr: paddr_i, data: data_i, be: be_i, size: data_size_i};
    if (commit) commit_mem[commit_wr] <= spec_mem[spec_rd];
  end

  // Commit queue pointers/count; head stays counted until the D$ reports completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      commit_rd  <= '0;
      commit_wr  <= '0;
      commit_cnt <= '0;
    end else begin
      if (commit) commit_wr <= commit_wr + 1'b1;
      if (pop)    commit_rd <= commit_rd + 1'b1;
      commit_cnt <= commit_cnt + (CMW+1)'(commit) - (CMW+1)'(pop);
    end
  end

  // Drain FSM; IDLE also reacts to the commit landing this cycle so the request follows one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if ((commit_cnt != '0) || commit) state <= REQ;
        REQ:     if (gnt_i) state <= WAIT;
        WAIT:    if (rvalid_i) state <= (commit_cnt > (CMW+1)'(1)) ? REQ : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_o   = (state == REQ);
  assign addr_o  = commit_mem[commit_rd].paddr;
  assign wdata_o = commit_mem[commit_rd].data;
  assign be_o    = commit_mem[commit_rd].be;
  assign size_o  = commit_mem[commit_rd].size;

  assign no_st_pending_o      = (commit_cnt == '0) && (state == IDLE);
  assign store_buffer_empty_o = (spec_cnt == '0) && no_st_pending_o;

`ifdef STB_PAGE_OFFSET_CHECK_EN
  logic unused_offset_bits;
  assign unused_offset_bits = ^page_offset_i[2:0];

  function automatic logic [SPW-1:0] spec_rel(input logic [SPW-1:0] idx, input logic [SPW-1:0] rd);
    return idx - rd;
  endfunction

  function automatic logic [CMW-1:0] commit_rel(input logic [CMW-1:0] idx, input logic [CMW-1:0] rd);
    return idx - rd;
  endfunction

  // Precise hazard check: any live entry in either queue aliasing the load's double-word offset
  always_comb begin
    page_offset_matches_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH_SPEC; i++) begin
      if (({1'b0, spec_rel(SPW'(i), spec_rd)} < spec_cnt) &&
          (spec_mem[i].paddr[11:3] == page_offset_i[11:3]))
        page_offset_matches_o = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH_COMMIT; i++) begin
      if (({1'b0, commit_rel(CMW'(i), commit_rd)} < commit_cnt) &&
          (commit_mem[i].paddr[11:3] == page_offset_i[11:3]))
        page_offset_matches_o = 1'b1;
    end
  end
`else
  logic unused_offset_bits;
  assign unused_offset_bits    = ^page_offset_i;
  assign page_offset_matches_o = !store_buffer_empty_o;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: directed stimulus with a queue model of the
// speculative side; committed stores are pushed to a scoreboard that a
// separate monitor checks at every D$ handshake.
module tb_store_commit_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        flush_i = 1'b0, valid_i = 1'b0, commit_i = 1'b0;
  logic [63:0] paddr_i = '0, data_i = '0;
  logic [7:0]  be_i = '0;
  logic [1:0]  data_size_i = '0;
  logic [11:0] page_offset_i = '0;
  logic        gnt_i = 1'b0, rvalid_i = 1'b0;
  logic        ready_o, commit_ready_o, no_st_pending_o, store_buffer_empty_o;
  logic        page_offset_matches_o, req_o;
  logic [63:0] addr_o, wdata_o;
  logic [7:0]  be_o;
  logic [1:0]  size_o;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
  } st_t;

  st_t exp_q[$];
  st_t spec_m[$];
  int  tests = 0, fails = 0;
  int  commits_total = 0, pops_total = 0, hs_cnt = 0;
  bit  gnt_en = 1'b1;

  store_commit_buffer #(.DEPTH_SPEC(4), .DEPTH_COMMIT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i),
    .data_size_i(data_size_i), .commit_i(commit_i), .commit_ready_o(commit_ready_o),
    .no_st_pending_o(no_st_pending_o), .store_buffer_empty_o(store_buffer_empty_o),
    .page_offset_i(page_offset_i), .page_offset_matches_o(page_offset_matches_o),
    .req_o(req_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .size_o(size_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle of stimulus; the model mirrors spec-queue behaviour and feeds the scoreboard
  task automatic cyc(input bit v, input logic [63:0] a, input logic [63:0] d,
                     input logic [7:0] b, input logic [1:0] s, input bit c, input bit f);
    st_t e;
    bit  rdy, cok;
    @(negedge clk_i);
    valid_i = v; paddr_i = a; data_i = d; be_i = b; data_size_i = s;
    commit_i = c; flush_i = f;
    rdy = (spec_m.size() != 4);
    cok = c && (spec_m.size() != 0) && ((commits_total - pops_total) != 8);
    if (cok) begin
      e = spec_m.pop_front();
      exp_q.push_back(e);
      commits_total++;
    end
    if (f) spec_m.delete();
    else if (v && rdy) begin
      e.addr = a; e.data = d; e.be = b; e.size = s;
      spec_m.push_back(e);
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // D$ responder: grant when enabled, complete two cycles after the grant
  initial begin
    int rv_delay;
    rv_delay = 0;
    forever begin
      @(negedge clk_i);
      gnt_i = 1'b0;
      rvalid_i = 1'b0;
      if (!rst_ni) rv_delay = 0;
      else if (rv_delay > 0) begin
        rv_delay--;
        if (rv_delay == 0) rvalid_i = 1'b1;
      end else if (req_o && gnt_en) begin
        gnt_i = 1'b1;
        rv_delay = 2;
      end
    end
  end

  always @(posedge clk_i) if (rvalid_i && rst_ni) pops_total <= pops_total + 1;

  // Monitor: every accepted D$ request must match the oldest committed store
  initial begin
    st_t e;
    forever begin
      @(negedge clk_i);
      #1;
      if (req_o && gnt_i) begin
        hs_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL dcache_write: unexpected request addr %0h", addr_o);
        end else begin
          e = exp_q.pop_front();
          if (addr_o !== e.addr || wdata_o !== e.data || be_o !== e.be || size_o !== e.size) begin
            fails++;
            $display("FAIL dcache_write: got %0h/%0h/%0h/%0h expected %0h/%0h/%0h/%0h",
                     addr_o, wdata_o, be_o, size_o, e.addr, e.data, e.be, e.size);
          end
        end
      end
    end
  end

  initial begin
    int n, hs0;
    bit exp_alias;
`ifdef STB_PAGE_OFFSET_CHECK_EN
    exp_alias = 1'b0;
`else
    exp_alias = 1'b1;
`endif
    // Reset
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_commit_ready", commit_ready_o, 1);
    chk("rst_no_st_pending", no_st_pending_o, 1);
    chk("rst_req", req_o, 0);
    chk("rst_sb_empty", store_buffer_empty_o, 1);
    chk("rst_page_match", page_offset_matches_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single store: push, commit, request next cycle, completion two cycles after grant
    cyc(1'b1, 64'h8000_0010, 64'hDEAD, 8'hFF, 2'd3, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    idle();
    chk("t2_req_after_commit", req_o, 1);
    chk("t2_pending_in_req", no_st_pending_o, 0);
    idle();
    chk("t2_req_low_in_wait", req_o, 0);
    idle();
    chk("t2_pending_in_wait", no_st_pending_o, 0);
    idle();
    chk("t2_pending_cleared", no_st_pending_o, 1);
    chk("t2_sb_empty", store_buffer_empty_o, 1);

    // Fill speculative queue, drop 5th push, flush
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 64'h1000 + 64'(i * 8), 64'h11 + 64'(i), 8'h0F, 2'd2, 1'b0, 1'b0);
    cyc(1'b1, 64'h1F00, 64'h99, 8'hFF, 2'd3, 1'b0, 1'b0);
    chk("t3_ready_full", ready_o, 0);
    chk("t3_sb_not_empty", store_buffer_empty_o, 0);
    cyc(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    idle();
    chk("t3_ready_after_flush", ready_o, 1);
    chk("t3_no_st_pending", no_st_pending_o, 1);
    chk("t3_sb_empty", store_buffer_empty_o, 1);
    idle();
    chk("t3_no_req", req_o, 0);

    // Eight commits with the D$ stalled, then release
    gnt_en = 1'b0;
    cyc(1'b1, 64'h2000, 64'hA5A5_0000, 8'h01, 2'd0, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++)
      cyc(1'b1, 64'h2000 + 64'(i * 8), 64'hA5A5_0000 + 64'(i), 8'h01 << i, 2'(i % 4), 1'b1, 1'b0);
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    chk("t4_commit_ready_at_7", commit_ready_o, 1);
    idle();
    chk("t4_commit_full", commit_ready_o, 0);
    chk("t4_req_held", req_o, 1);
    gnt_en = 1'b1;
    n = 0;
    while (commit_ready_o !== 1'b1 && n < 20) begin idle(); n++; end
    chk("t4_commit_ready_after_pop", commit_ready_o, 1);
    n = 0;
    while (no_st_pending_o !== 1'b1 && n < 100) begin idle(); n++; end
    chk("t4_drained", no_st_pending_o, 1);

    // Flush with same-cycle commit: only the head survives
    hs0 = hs_cnt;
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 64'h3000 + 64'(i * 8), 64'hC0DE_0000 + 64'(i), 8'hF0, 2'd1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
    n = 0;
    while (store_buffer_empty_o !== 1'b1 && n < 50) begin idle(); n++; end
    chk("t5_sb_empty", store_buffer_empty_o, 1);
    chk("t5_one_write", 64'(hs_cnt - hs0), 1);
    chk("t5_ready", ready_o, 1);

    // Page-offset hazard: speculative entry, then in-flight commit head
    cyc(1'b1, 64'h8000_10A8, 64'h77, 8'hFF, 2'd3, 1'b0, 1'b0);
    idle();
    page_offset_i = 12'h0A8; #1;
    chk("t6_spec_match", page_offset_matches_o, 1);
    page_offset_i = 12'h0AF; #1;
    chk("t6_spec_match_low_bits", page_offset_matches_o, 1);
    page_offset_i = 12'h0B0; #1;
    chk("t6_spec_other_dword", page_offset_matches_o, 64'(exp_alias));
    gnt_en = 1'b0;
    cyc(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    idle();
    page_offset_i = 12'h0A8; #1;
    chk("t6_head_match", page_offset_matches_o, 1);
    page_offset_i = 12'h0B0; #1;
    chk("t6_head_other_dword", page_offset_matches_o, 64'(exp_alias));
    gnt_en = 1'b1;
    n = 0;
    while (store_buffer_empty_o !== 1'b1 && n < 50) begin idle(); n++; end
    page_offset_i = 12'h0A8; #1;
    chk("t6_empty_no_match", page_offset_matches_o, 0);

    idle();
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
